// File: rtl/signal_pkg.sv
// Shared types and helpers for the N-approach signal controller family.
// Holds the phase enum, the active-index width rule and the round-robin search.
package signal_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    localparam int unsigned MAX_APP   = 8;
    localparam int unsigned MAX_IDX_W = 3;

    // Index width for n approaches; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of pend searching start+1 .. start+n (mod n); start if none.
    function automatic logic [MAX_IDX_W-1:0] rr_next(
        input logic [MAX_APP-1:0]   pend,
        input logic [MAX_IDX_W-1:0] start,
        input int unsigned          n
    );
        logic [MAX_IDX_W-1:0] sel;
        logic                 found;
        int unsigned          j;
        sel   = start;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_APP; k++) begin
            j = 32'(start) + k;
            if (j >= n) begin
                j = j - n;
            end
            if (!found && (k <= n) && (j < MAX_APP) && pend[j[MAX_IDX_W-1:0]]) begin
                sel   = j[MAX_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/signal_rr_arb.sv
// Combinational round-robin selector: next pending index after a start index.
// Returns the start index unchanged when nothing is pending.
module signal_rr_arb
    import signal_pkg::*;
#(
    parameter int unsigned N_APP = 2,
    parameter int unsigned IDX_W = idx_w(N_APP)
) (
    input  logic [N_APP-1:0] i_pending,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_next_c
);

    logic [MAX_APP-1:0]   w_pend;
    logic [MAX_IDX_W-1:0] w_start;
    logic [MAX_IDX_W-1:0] w_next;

    assign w_pend   = MAX_APP'(i_pending);
    assign w_start  = MAX_IDX_W'(i_start);
    assign w_next   = rr_next(w_pend, w_start, N_APP);
    assign o_next_c = IDX_W'(w_next);

endmodule

// File: rtl/signal_ctrl_n.sv
// N-approach traffic signal controller: latched requests, round-robin green,
// min/max green, yellow and all-red clearance. Optional preemption: SIGNAL_PREEMPT_EN.
module signal_ctrl_n
    import signal_pkg::*;
#(
    parameter  int unsigned N_APP       = 2,
    parameter  int unsigned CNT_W       = 8,
    parameter  int unsigned T_MIN_GREEN = 4,
    parameter  int unsigned T_MAX_GREEN = 12,
    parameter  int unsigned T_YELLOW    = 2,
    parameter  int unsigned T_ALLRED    = 1,
    localparam int unsigned IDX_W       = idx_w(N_APP)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_APP-1:0] req,
`ifdef SIGNAL_PREEMPT_EN
    input  logic             preempt,
    input  logic [IDX_W-1:0] preempt_app,
`endif
    output logic [N_APP-1:0] go,
    output logic [N_APP-1:0] yellow,
    output logic [N_APP-1:0] stop,
    output logic [IDX_W-1:0] active,
    output logic [N_APP-1:0] pending
);

    localparam logic [CNT_W-1:0] TMR_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(T_ALLRED - 1);

    phase_t           r_state;
    logic [IDX_W-1:0] r_active;
    logic [CNT_W-1:0] r_timer;
    logic [N_APP-1:0] r_pending;
    logic [N_APP-1:0] r_go;
    logic [N_APP-1:0] r_yellow;
    logic [N_APP-1:0] r_stop;

    phase_t           w_state_n;
    logic [IDX_W-1:0] w_active_n;
    logic [CNT_W-1:0] w_timer_n;
    logic [N_APP-1:0] w_pending_n;
    logic [N_APP-1:0] w_go_n;
    logic [N_APP-1:0] w_yellow_n;
    logic [N_APP-1:0] w_stop_n;

    logic [N_APP-1:0] w_act_oh;
    logic [N_APP-1:0] w_next_oh;
    logic [N_APP-1:0] w_others;
    logic [N_APP-1:0] w_set;
    logic [N_APP-1:0] w_clr;
    logic [IDX_W-1:0] w_rr_next;
    logic             w_hold;
    logic             w_min_ok;
    logic             w_pre_valid;
    logic [IDX_W-1:0] w_pre_app;

    // Preemption only counts when it names an existing approach.
`ifdef SIGNAL_PREEMPT_EN
    assign w_pre_valid = preempt && (32'(preempt_app) < N_APP);
    assign w_pre_app   = preempt_app;
`else
    assign w_pre_valid = 1'b0;
    assign w_pre_app   = '0;
`endif

    assign w_act_oh = N_APP'(1) << r_active;
    assign w_others = r_pending & ~w_act_oh;
    assign w_min_ok = (r_timer >= MIN_M1) || (r_timer >= MAX_M1);

    signal_rr_arb #(
        .N_APP (N_APP),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_pending (r_pending),
        .i_start   (r_active),
        .o_next_c  (w_rr_next)
    );

    // Phase sequencing, request latch and next lamp pattern.
    always_comb begin
        w_state_n  = r_state;
        w_active_n = r_active;
        case (r_state)
            GREEN: begin
                if (w_pre_valid) begin
                    if (w_pre_app != r_active) begin
                        w_state_n = YELLOW;
                    end
                end else if ((|w_others) && w_min_ok) begin
                    w_state_n = YELLOW;
                end
            end
            YELLOW: begin
                if (r_timer >= YEL_M1) begin
                    w_state_n = ALLRED;
                end
            end
            ALLRED: begin
                if (r_timer >= AR_M1) begin
                    w_state_n  = GREEN;
                    w_active_n = w_pre_valid ? w_pre_app : w_rr_next;
                end
            end
            default: begin
                w_state_n  = GREEN;
                w_active_n = '0;
            end
        endcase

        if (w_state_n != r_state) begin
            w_timer_n = '0;
        end else if (r_timer != TMR_SAT) begin
            w_timer_n = r_timer + CNT_W'(1);
        end else begin
            w_timer_n = r_timer;
        end

        // The active approach's own request is ignored while it shows go or yellow.
        w_hold      = (r_state == GREEN) || (r_state == YELLOW);
        w_set       = req & ~(w_hold ? w_act_oh : '0);
        w_next_oh   = N_APP'(1) << w_active_n;
        w_clr       = ((w_state_n == GREEN) && (r_state != GREEN)) ? w_next_oh : '0;
        w_pending_n = (r_pending | w_set) & ~w_clr;

        w_go_n     = (w_state_n == GREEN)  ? w_next_oh : '0;
        w_yellow_n = (w_state_n == YELLOW) ? w_next_oh : '0;
        w_stop_n   = ~(w_go_n | w_yellow_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= GREEN;
            r_active  <= '0;
            r_timer   <= '0;
            r_pending <= '0;
            r_go      <= N_APP'(1);
            r_yellow  <= '0;
            r_stop    <= ~(N_APP'(1));
        end else begin
            r_state   <= w_state_n;
            r_active  <= w_active_n;
            r_timer   <= w_timer_n;
            r_pending <= w_pending_n;
            r_go      <= w_go_n;
            r_yellow  <= w_yellow_n;
            r_stop    <= w_stop_n;
        end
    end

    assign go      = r_go;
    assign yellow  = r_yellow;
    assign stop    = r_stop;
    assign active  = r_active;
    assign pending = r_pending;

endmodule

// File: tb/tb_signal_ctrl_n.sv
// Directed bench for signal_ctrl_n: a 2-approach and a 3-approach instance.
// Cycle c means the interval after the c-th rising edge following reset release.
module tb_signal_ctrl_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst2;
    logic [1:0] req2, go2, yel2, stp2, pnd2;
    logic       act2;

    logic       rst3;
    logic [2:0] req3, go3, yel3, stp3, pnd3;
    logic [1:0] act3;
`ifdef SIGNAL_PREEMPT_EN
    logic       pre3;
    logic [1:0] papp3;
`endif

    int seq[5] = '{0, 1, 2, 1, 2};

    signal_ctrl_n #(.N_APP(2)) dut2 (
        .clk(clk), .rst(rst2), .req(req2),
`ifdef SIGNAL_PREEMPT_EN
        .preempt(1'b0), .preempt_app(1'b0),
`endif
        .go(go2), .yellow(yel2), .stop(stp2), .active(act2), .pending(pnd2)
    );

    signal_ctrl_n #(.N_APP(3)) dut3 (
        .clk(clk), .rst(rst3), .req(req3),
`ifdef SIGNAL_PREEMPT_EN
        .preempt(pre3), .preempt_app(papp3),
`endif
        .go(go3), .yellow(yel3), .stop(stp3), .active(act3), .pending(pnd3)
    );

    task automatic reset2();
        rst2 = 1'b1; req2 = 2'b00;
        @(posedge clk); #1;
        rst2 = 1'b0;
    endtask

    task automatic reset3();
        rst3 = 1'b1; req3 = 3'b000;
`ifdef SIGNAL_PREEMPT_EN
        pre3 = 1'b0; papp3 = 2'd0;
`endif
        @(posedge clk); #1;
        rst3 = 1'b0;
    endtask

    task automatic test_reset();
        reset2();
        for (int c = 0; c < 20; c++) begin
            total++; if (go2 !== 2'b01) begin bad++; $display("FAIL idle_go c=%0d got=%b exp=01", c, go2); end
            total++; if (stp2 !== 2'b10) begin bad++; $display("FAIL idle_stop c=%0d got=%b exp=10", c, stp2); end
            total++; if (yel2 !== 2'b00) begin bad++; $display("FAIL idle_yellow c=%0d got=%b exp=00", c, yel2); end
            total++; if (act2 !== 1'b0) begin bad++; $display("FAIL idle_active c=%0d got=%b exp=0", c, act2); end
            total++; if (pnd2 !== 2'b00) begin bad++; $display("FAIL idle_pending c=%0d got=%b exp=00", c, pnd2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_handoff();
        logic [1:0] eg, ey, ep;
        logic       ea;
        reset2();
        for (int c = 0; c < 18; c++) begin
            eg = (c < 12) ? 2'b01 : (c >= 15) ? 2'b10 : 2'b00;
            ey = (c == 12 || c == 13) ? 2'b01 : 2'b00;
            ep = (c >= 11 && c <= 14) ? 2'b10 : 2'b00;
            ea = (c >= 15);
            total++; if (go2 !== eg) begin bad++; $display("FAIL handoff_go c=%0d got=%b exp=%b", c, go2, eg); end
            total++; if (yel2 !== ey) begin bad++; $display("FAIL handoff_yellow c=%0d got=%b exp=%b", c, yel2, ey); end
            total++; if (stp2 !== ~(eg | ey)) begin bad++; $display("FAIL handoff_stop c=%0d got=%b exp=%b", c, stp2, ~(eg | ey)); end
            total++; if (pnd2 !== ep) begin bad++; $display("FAIL handoff_pending c=%0d got=%b exp=%b", c, pnd2, ep); end
            total++; if (act2 !== ea) begin bad++; $display("FAIL handoff_active c=%0d got=%b exp=%b", c, act2, ea); end
            req2 = (c == 10) ? 2'b10 : 2'b00;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] oh, eg, ey;
        int         p, w, s;
        reset3();
        req3 = 3'b110;
        for (int c = 0; c < 35; c++) begin
            p  = c / 7;
            w  = c % 7;
            oh = 3'b001 << seq[p];
            eg = (w < 4) ? oh : 3'b000;
            ey = (w == 4 || w == 5) ? oh : 3'b000;
            total++; if (go3 !== eg) begin bad++; $display("FAIL rr_go c=%0d got=%b exp=%b", c, go3, eg); end
            total++; if (yel3 !== ey) begin bad++; $display("FAIL rr_yellow c=%0d got=%b exp=%b", c, yel3, ey); end
            total++; if (stp3 !== ~(eg | ey)) begin bad++; $display("FAIL rr_stop c=%0d got=%b exp=%b", c, stp3, ~(eg | ey)); end
            total++; if (act3 !== 2'(seq[p])) begin bad++; $display("FAIL rr_active c=%0d got=%0d exp=%0d", c, act3, seq[p]); end
            for (int i = 0; i < 3; i++) begin
                s = int'(go3[i]) + int'(yel3[i]) + int'(stp3[i]);
                total++; if (s != 1) begin bad++; $display("FAIL rr_onehot c=%0d app=%0d got=%0d exp=1", c, i, s); end
            end
            @(posedge clk); #1;
        end
        req3 = 3'b000;
    endtask

    task automatic test_active_req();
        logic [1:0] eg, ey, ep;
        reset2();
        for (int c = 0; c < 15; c++) begin
            eg = (c < 7) ? 2'b01 : (c >= 10) ? 2'b10 : 2'b00;
            ey = (c == 7 || c == 8) ? 2'b01 : 2'b00;
            ep = (c >= 6 && c <= 9) ? 2'b10 : 2'b00;
            total++; if (pnd2 !== ep) begin bad++; $display("FAIL own_req_pending c=%0d got=%b exp=%b", c, pnd2, ep); end
            total++; if (go2 !== eg) begin bad++; $display("FAIL own_req_go c=%0d got=%b exp=%b", c, go2, eg); end
            total++; if (yel2 !== ey) begin bad++; $display("FAIL own_req_yellow c=%0d got=%b exp=%b", c, yel2, ey); end
            req2 = {(c == 5) ? 1'b1 : 1'b0, (c <= 8) ? 1'b1 : 1'b0};
            @(posedge clk); #1;
        end
        req2 = 2'b00;
    endtask

    task automatic test_async_reset();
        reset2();
        for (int c = 0; c < 7; c++) begin
            req2 = (c == 5) ? 2'b10 : 2'b00;
            @(posedge clk); #1;
        end
        total++; if (yel2 !== 2'b01) begin bad++; $display("FAIL arst_pre_yellow got=%b exp=01", yel2); end
        total++; if (pnd2 !== 2'b10) begin bad++; $display("FAIL arst_pre_pending got=%b exp=10", pnd2); end
        #2 rst2 = 1'b1;
        #1;
        total++; if (go2 !== 2'b01) begin bad++; $display("FAIL arst_go got=%b exp=01", go2); end
        total++; if (yel2 !== 2'b00) begin bad++; $display("FAIL arst_yellow got=%b exp=00", yel2); end
        total++; if (stp2 !== 2'b10) begin bad++; $display("FAIL arst_stop got=%b exp=10", stp2); end
        total++; if (pnd2 !== 2'b00) begin bad++; $display("FAIL arst_pending got=%b exp=00", pnd2); end
        total++; if (act2 !== 1'b0) begin bad++; $display("FAIL arst_active got=%b exp=0", act2); end
        #1 rst2 = 1'b0;
        @(posedge clk); #1;
        total++; if (go2 !== 2'b01) begin bad++; $display("FAIL arst_after_go got=%b exp=01", go2); end
        total++; if (pnd2 !== 2'b00) begin bad++; $display("FAIL arst_after_pending got=%b exp=00", pnd2); end
    endtask

`ifdef SIGNAL_PREEMPT_EN
    task automatic test_preempt();
        logic [2:0] eg, ey, ep;
        logic [1:0] ea;
        reset3();
        for (int c = 0; c < 20; c++) begin
            eg = (c < 2) ? 3'b001 : (c >= 5 && c <= 15) ? 3'b100 : (c == 19) ? 3'b001 : 3'b000;
            ey = (c == 2 || c == 3) ? 3'b001 : (c == 16 || c == 17) ? 3'b100 : 3'b000;
            ep = (c == 0) ? 3'b000 : (c <= 6) ? 3'b010 : (c <= 18) ? 3'b011 : 3'b010;
            ea = (c >= 5 && c <= 18) ? 2'd2 : 2'd0;
            total++; if (go3 !== eg) begin bad++; $display("FAIL preempt_go c=%0d got=%b exp=%b", c, go3, eg); end
            total++; if (yel3 !== ey) begin bad++; $display("FAIL preempt_yellow c=%0d got=%b exp=%b", c, yel3, ey); end
            total++; if (stp3 !== ~(eg | ey)) begin bad++; $display("FAIL preempt_stop c=%0d got=%b exp=%b", c, stp3, ~(eg | ey)); end
            total++; if (pnd3 !== ep) begin bad++; $display("FAIL preempt_pending c=%0d got=%b exp=%b", c, pnd3, ep); end
            total++; if (act3 !== ea) begin bad++; $display("FAIL preempt_active c=%0d got=%0d exp=%0d", c, act3, ea); end
            req3  = (c == 0) ? 3'b010 : (c == 6) ? 3'b001 : 3'b000;
            pre3  = (c >= 1 && c <= 14);
            papp3 = 2'd2;
            @(posedge clk); #1;
        end
        pre3 = 1'b0;
    endtask
`endif

    initial begin
        rst2 = 1'b1; req2 = 2'b00;
        rst3 = 1'b1; req3 = 3'b000;
`ifdef SIGNAL_PREEMPT_EN
        pre3 = 1'b0; papp3 = 2'd0;
`endif
        #12;
        test_reset();
        test_handoff();
        test_round_robin();
        test_active_req();
        test_async_reset();
`ifdef SIGNAL_PREEMPT_EN
        test_preempt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
